// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: per-channel half-period, phase and
// polarity, with shadowed configuration that only lands at full-period boundaries.
module clock_divider_multi #(
  parameter int NUM_CH       = 4,
  parameter int CNT_WIDTH    = 8,
  parameter int CH_SEL_W     = 2,
  parameter int DEFAULT_HALF = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 cfg_we,
  input  logic [CH_SEL_W-1:0]  cfg_ch,
  input  logic [CNT_WIDTH-1:0] cfg_half,
  input  logic [CNT_WIDTH-1:0] cfg_phase,
  input  logic                 cfg_invert,
  input  logic                 sync,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    tick_rise,
  output logic [NUM_CH-1:0]    cfg_busy
);

  localparam logic [CNT_WIDTH-1:0] ONE      = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] HALF_RST = CNT_WIDTH'(DEFAULT_HALF);

  // A programmed half-period of zero would never terminate a count, so it becomes one
  logic [CNT_WIDTH-1:0] wr_half_s;
  assign wr_half_s = (cfg_half == {CNT_WIDTH{1'b0}}) ? ONE : cfg_half;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt_r, half_r, phase_r, sh_half_r, sh_phase_r;
    logic                 q_r, inv_r, sh_inv_r, pend_r, clk_r, tick_r;
    logic [CNT_WIDTH-1:0] cnt_nx_s, half_nx_s, phase_nx_s, sh_half_nx_s, sh_phase_nx_s;
    logic                 q_nx_s, inv_nx_s, sh_inv_nx_s, pend_nx_s, clk_nx_s, tick_nx_s;
    logic [CNT_WIDTH-1:0] sel_half_s, sel_phase_s;
    logic                 sel_inv_s, wr_s, term_s, bnd_s;

    assign wr_s   = cfg_we && (cfg_ch == CH_SEL_W'(g));
    assign term_s = (cnt_r == half_r - ONE);
    assign bnd_s  = enable && term_s && q_r;

    // Next-state: sync realignment, counting, boundary loads and shadow writes
    always_comb begin
      cnt_nx_s      = cnt_r;
      q_nx_s        = q_r;
      half_nx_s     = half_r;
      phase_nx_s    = phase_r;
      inv_nx_s      = inv_r;
      sh_half_nx_s  = sh_half_r;
      sh_phase_nx_s = sh_phase_r;
      sh_inv_nx_s   = sh_inv_r;
      pend_nx_s     = pend_r;
      sel_half_s    = half_r;
      sel_phase_s   = phase_r;
      sel_inv_s     = inv_r;
      // Config that would become active now: a same-cycle write beats a pending shadow
      if (wr_s) begin
        sel_half_s  = wr_half_s;
        sel_phase_s = cfg_phase;
        sel_inv_s   = cfg_invert;
      end else if (pend_r) begin
        sel_half_s  = sh_half_r;
        sel_phase_s = sh_phase_r;
        sel_inv_s   = sh_inv_r;
      end else begin
        sel_inv_s   = inv_r;
      end
      if (sync) begin
        half_nx_s     = sel_half_s;
        phase_nx_s    = sel_phase_s;
        inv_nx_s      = sel_inv_s;
        sh_half_nx_s  = sel_half_s;
        sh_phase_nx_s = sel_phase_s;
        sh_inv_nx_s   = sel_inv_s;
        pend_nx_s     = 1'b0;
        if ({1'b0, sel_phase_s} < {1'b0, sel_half_s}) begin
          q_nx_s   = 1'b0;
          cnt_nx_s = sel_phase_s;
        end else if ({1'b0, sel_phase_s} < {sel_half_s, 1'b0}) begin
          q_nx_s   = 1'b1;
          cnt_nx_s = sel_phase_s - sel_half_s;
        end else begin
          q_nx_s   = 1'b0;
          cnt_nx_s = {CNT_WIDTH{1'b0}};
        end
      end else begin
        if (enable && term_s) begin
          cnt_nx_s = {CNT_WIDTH{1'b0}};
          q_nx_s   = ~q_r;
        end else if (enable) begin
          cnt_nx_s = cnt_r + ONE;
        end else begin
          cnt_nx_s = cnt_r;
        end
        if (bnd_s && (wr_s || pend_r)) begin
          half_nx_s     = sel_half_s;
          phase_nx_s    = sel_phase_s;
          inv_nx_s      = sel_inv_s;
          sh_half_nx_s  = sel_half_s;
          sh_phase_nx_s = sel_phase_s;
          sh_inv_nx_s   = sel_inv_s;
          pend_nx_s     = 1'b0;
        end else if (wr_s) begin
          sh_half_nx_s  = wr_half_s;
          sh_phase_nx_s = cfg_phase;
          sh_inv_nx_s   = cfg_invert;
          pend_nx_s     = 1'b1;
        end else begin
          pend_nx_s     = pend_r;
        end
      end
      clk_nx_s  = q_nx_s ^ inv_nx_s;
      tick_nx_s = enable & ~clk_r & clk_nx_s;
    end

    // Channel state and registered outputs
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_r      <= {CNT_WIDTH{1'b0}};
        q_r        <= 1'b0;
        half_r     <= HALF_RST;
        phase_r    <= {CNT_WIDTH{1'b0}};
        inv_r      <= 1'b0;
        sh_half_r  <= HALF_RST;
        sh_phase_r <= {CNT_WIDTH{1'b0}};
        sh_inv_r   <= 1'b0;
        pend_r     <= 1'b0;
        clk_r      <= 1'b0;
        tick_r     <= 1'b0;
      end else begin
        cnt_r      <= cnt_nx_s;
        q_r        <= q_nx_s;
        half_r     <= half_nx_s;
        phase_r    <= phase_nx_s;
        inv_r      <= inv_nx_s;
        sh_half_r  <= sh_half_nx_s;
        sh_phase_r <= sh_phase_nx_s;
        sh_inv_r   <= sh_inv_nx_s;
        pend_r     <= pend_nx_s;
        clk_r      <= clk_nx_s;
        tick_r     <= tick_nx_s;
      end
    end

    assign clk_out[g]   = clk_r;
    assign tick_rise[g] = tick_r;
    assign cfg_busy[g]  = pend_r;
  end

endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Parametrised, multi-channel successor to the fixed divide-by-2 processor/regfile clock generation.
- Derives NUM_CH divided clocks from one master clock. Each channel has a runtime-programmable half-period, phase offset and polarity.
- Configuration updates are glitch-free: they apply only at period boundaries.
- A global sync realigns all channels. The block sits at the top level and feeds processor, regfile and peripheral clocks.

Parameters:
- NUM_CH, 4, number of output channels (1..2^CH_SEL_W)
- CNT_WIDTH, 8, width of half-period/phase counters
- CH_SEL_W, 2, width of cfg_ch
- DEFAULT_HALF, 1, half-period loaded at reset (1 = divide-by-2)

Ports:
- clock  in  1  master clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  global run; low = all channels freeze
- cfg_we  in  1  config write strobe
- cfg_ch  in  CH_SEL_W  target channel; values >= NUM_CH are ignored
- cfg_half  in  CNT_WIDTH  half-period in master cycles; 0 is treated as 1
- cfg_phase  in  CNT_WIDTH  offset applied at sync, in master cycles
- cfg_invert  in  1  output polarity
- sync  in  1  realign all channels this cycle
- clk_out  out  NUM_CH  divided clocks, registered
- tick_rise  out  NUM_CH  registered pulse, high in the first high cycle of each clk_out rise
- cfg_busy  out  NUM_CH  shadow config pending for the channel

Behaviour:
- Reset (async): per channel, cnt=0, q=0, active half=DEFAULT_HALF, phase=0, invert=0. Shadow = active values, pending=0. clk_out=0, tick_rise=0, cfg_busy=0. Reset takes effect in the same timestep, not at an edge.
- Per-channel state: counter cnt, internal level q, active {half, phase, invert}, shadow {half, phase, invert}, pending bit.
- Counting (enable=1, sync=0):
  - If cnt == half-1: cnt<=0 and q toggles.
  - Otherwise cnt<=cnt+1.
- Boundary: cycle where q toggles 1->0 (end of a full period). At a boundary with pending=1, shadow is copied to active and pending<=0. The new half takes effect from the next cycle.
- Output: clk_out <= q_next ^ invert_next. Polarity changes occur only at a boundary, so no runt pulses.
- tick_rise <= ~clk_out & clk_out_next. It is 0 whenever enable=0.
- Config write (cfg_we, valid cfg_ch): writes the shadow and sets pending. A half value of 0 is stored as 1. A write coinciding with that channel's boundary is loaded directly into active, with pending=0.
- Writes are accepted regardless of enable. A later write before the boundary overwrites the shadow; the last write wins.
- Sync (acts regardless of enable; priority over counting): for every channel, pending shadow loads into active, then position is set from phase p:
  - p < half: q=0, cnt=p.
  - half <= p < 2*half: q=1, cnt=p-half.
  - p >= 2*half: clamped to 0.
- cfg_we + sync on the same channel in the same cycle: the written values are used by the sync.
- enable=0: cnt, q and clk_out hold. No boundary loads occur. Pending is retained.
- Resume after enable returns high: counting continues from the held state, with no extra edge.
- cfg_busy = pending bits (registered state).
- Latency: config write to effect is at most one full active period + 1 cycle. Sync to aligned outputs is 1 cycle.
- Widths: cnt compare is CNT_WIDTH unsigned. cnt never exceeds half-1, so no wrap is possible. Phase clamp uses a CNT_WIDTH+1 compare against 2*half.

Test Plan:
1. Release reset, enable=1, no config -> every clk_out toggles each cycle: 0,1,0,1... tick_rise high on clk_out high cycles 1,3,5.
2. Write ch1 half=3 at cycle 5 -> cfg_busy[1]=1 until the next 1->0 of ch1, then clk_out[1] is 3 high / 3 low (period 6). Other channels are unaffected.
3. Write ch2 half=0, invert=1 -> after the boundary, ch2 runs as divide-by-2 inverted. No single-cycle runt is seen at the switchover.
4. Configure ch0 half=2 phase=0 and ch3 half=2 phase=2, then pulse sync -> one cycle later ch3 is exactly 180° from ch0: ch0 = 0011..., ch3 = 1100....
5. Drop enable for 5 cycles mid-period -> clk_out holds its value, tick_rise=0. On re-enable the remaining count completes, with no extra or missing edges.
6. Assert reset asynchronously mid-period with pending config -> clk_out=0 and cfg_busy=0 immediately. After release, default divide-by-2 resumes and the pending write is discarded.
